// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit between ID and EX: per-operand forwarding selects, load-use / long-latency stall
// generation with a per-register countdown scoreboard, and a saturating stall-cycle counter.
module hazard_scoreboard_unit #(
  parameter int RA_W      = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LAT_W     = 4,
  parameter int SCNT_W    = 32,
  localparam int FS_W     = $clog2(FWD_DEPTH + 1),
  localparam int NUM_REGS = 2 ** RA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*RA_W-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      id_wr_en,
  input  logic [RA_W-1:0]           id_rd,
  input  logic [LAT_W-1:0]          id_lat,
  input  logic                      flush,
  input  logic                      idex_mem_read,
  input  logic [RA_W-1:0]           idex_rd,
  input  logic [NUM_SRC*RA_W-1:0]   ex_rs,
  input  logic [FWD_DEPTH-1:0]      stg_wr_en,
  input  logic [FWD_DEPTH*RA_W-1:0] stg_rd,
  output logic [NUM_SRC*FS_W-1:0]   fwd_sel,
  output logic                      stall,
  output logic [SCNT_W-1:0]         stall_cycles
);

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic             lu_haz;
  logic             sb_haz;
  logic             waw_haz;
  logic             issue;

  // Scan from the farthest stage inward so the nearest matching stage is the last write.
  always_comb begin
    fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (stg_wr_en[k-1] &&
            stg_rd[(k-1)*RA_W +: RA_W] != '0 &&
            stg_rd[(k-1)*RA_W +: RA_W] == ex_rs[s*RA_W +: RA_W]) begin
          fwd_sel[s*FS_W +: FS_W] = FS_W'(k);
        end
      end
    end
  end

  always_comb begin
    lu_haz = 1'b0;
    sb_haz = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_rs_used[s] && idex_mem_read && idex_rd != '0 &&
          idex_rd == id_rs[s*RA_W +: RA_W]) begin
        lu_haz = 1'b1;
      end
      if (id_rs_used[s] && id_rs[s*RA_W +: RA_W] != '0 &&
          cnt[id_rs[s*RA_W +: RA_W]] != '0) begin
        sb_haz = 1'b1;
      end
    end
    waw_haz = id_wr_en && id_rd != '0 && cnt[id_rd] != '0;
  end

  assign stall = id_valid && !flush && (lu_haz || sb_haz || waw_haz);
  assign issue = id_valid && !flush && !stall && id_wr_en && id_rd != '0 && id_lat != '0;

  // Entry 0 is tied to zero so x0 can never look busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r == 0) begin
          cnt[r] <= '0;
        end else if (issue && id_rd == RA_W'(r)) begin
          cnt[r] <= id_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + SCNT_W'(1);
    end
  end

endmodule
